// File: rtl/quad_pkg.sv
// Shared phase encodings and step classification for the quadrature decoder.
// A step is legal only between neighbouring phases of the Gray cycle 00->01->11->10.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } step_t;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic step_t classify_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    if (cur == prev)                   s = STEP_NONE;
    else if (cur == next_phase(prev))  s = STEP_FWD;
    else if (prev == next_phase(cur))  s = STEP_REV;
    else                               s = STEP_ILL;
    return s;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Encoder pins, clear and the step/position outputs of the quadrature decoder.
// The decoder side uses the master modport; the consuming counter/datapath uses slave.
interface quadrature_decoder_if #(parameter int W = 16);
  logic         a_in;
  logic         b_in;
  logic         clr;
  logic         up;
  logic         down;
  logic         dir;
  logic [W-1:0] pos;
  logic         err;

  modport master (input a_in, b_in, clr, output up, down, dir, pos, err);
  modport slave  (output a_in, b_in, clr, input up, down, dir, pos, err);
endinterface

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser plus joint {A,B} stability filter; acc_vld pulses for one
// cycle whenever a new pair has held FILT_CYC cycles (including the first one).
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ab_in,
  output logic [1:0] acc,
  output logic       acc_vld
);

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYC);

  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]    vld_q, vld_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    acc_q, acc_d;
  logic          have_q, have_d;
  logic          acc_vld_q, acc_vld_d;

  always_comb begin
    sync1_d   = ab_in;
    sync2_d   = sync1_q;
    vld_d     = {vld_q[0], 1'b1};
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    have_d    = have_q;
    acc_vld_d = 1'b0;
    // sync2 still holds the reset value until two edges after reset release
    if (!vld_q[1]) begin
      cnt_d = '0;
    end else begin
      if (cnt_q == '0 || sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CNT_MAX && (!have_q || cand_d != acc_q)) begin
        acc_d     = cand_d;
        have_d    = 1'b1;
        acc_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= PH_00;
      sync2_q   <= PH_00;
      vld_q     <= '0;
      cand_q    <= PH_00;
      cnt_q     <= '0;
      acc_q     <= PH_00;
      have_q    <= 1'b0;
      acc_vld_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      vld_q     <= vld_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      have_q    <= have_d;
      acc_vld_q <= acc_vld_d;
    end
  end

  assign acc     = acc_q;
  assign acc_vld = acc_vld_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder top: primes on the first filtered phase, then turns each
// accepted phase change into an up/down pulse, a direction and a wrapping position.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int W        = 16,
  parameter int FILT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  quadrature_decoder_if.master bus
);

  logic [1:0]   acc;
  logic         acc_vld;
  step_t        step;

  logic         primed_q, primed_d;
  logic [1:0]   base_q, base_d;
  logic         up_q, up_d, down_q, down_d, dir_q, dir_d, err_q, err_d;
  logic [W-1:0] pos_q, pos_d;

  quad_input_filter #(.FILT_CYC(FILT_CYC)) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ab_in   ({bus.a_in, bus.b_in}),
    .acc     (acc),
    .acc_vld (acc_vld)
  );

  always_comb begin
    primed_d = primed_q;
    base_d   = base_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    err_d    = err_q;
    step     = STEP_NONE;
    // Baseline always follows the accepted pair, even across an illegal jump
    if (acc_vld) begin
      base_d = acc;
      if (!primed_q) primed_d = 1'b1;
      else           step = classify_step(base_q, acc);
    end
    case (step)
      STEP_FWD: begin up_d = 1'b1; dir_d = 1'b1; pos_d = pos_q + W'(1); end
      STEP_REV: begin down_d = 1'b1; dir_d = 1'b0; pos_d = pos_q - W'(1); end
      STEP_ILL: err_d = 1'b1;
      default:  ;
    endcase
    if (bus.clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= 1'b0;
      base_q   <= PH_00;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      dir_q    <= 1'b0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      primed_q <= primed_d;
      base_q   <= base_d;
      up_q     <= up_d;
      down_q   <= down_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

  assign bus.up   = up_q;
  assign bus.down = down_q;
  assign bus.dir  = dir_q;
  assign bus.pos  = pos_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: a sample-history model predicts every
// output each cycle, and literal checks pin the key scenarios.
module tb_quadrature_decoder;

  localparam int W = 16;
  localparam int F = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_up  = 0;
  int n_down = 0;

  quadrature_decoder_if #(.W(W)) bus_if ();

  quadrature_decoder #(.W(W), .FILT_CYC(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Position of a phase around the forward Gray cycle
  function automatic int gidx(input logic [1:0] p);
    int r;
    case (p)
      2'b00:   r = 0;
      2'b01:   r = 1;
      2'b11:   r = 2;
      default: r = 3;
    endcase
    return r;
  endfunction

  // Model: a pair is accepted once F consecutive edge samples agree; the step it
  // implies shows up on the following edge.
  logic [1:0]   hist[$];
  logic [1:0]   m_acc, m_old, m_new;
  bit           m_have, m_pend, m_first;
  logic         m_up, m_down, m_dir, m_err;
  logic [W-1:0] m_pos;

  always @(posedge clk or posedge rst) begin
    int           d;
    logic [W-1:0] np;
    logic         ne;
    logic [1:0]   v;
    bit           same;
    if (rst) begin
      hist.delete();
      m_acc <= 2'b00; m_old <= 2'b00; m_new <= 2'b00;
      m_have <= 1'b0; m_pend <= 1'b0; m_first <= 1'b0;
      m_up <= 1'b0; m_down <= 1'b0; m_dir <= 1'b0; m_err <= 1'b0; m_pos <= '0;
    end else begin
      np = m_pos;
      ne = m_err;
      m_up   <= 1'b0;
      m_down <= 1'b0;
      if (m_pend && !m_first) begin
        d = (gidx(m_new) - gidx(m_old) + 4) % 4;
        if (d == 1) begin
          m_up <= 1'b1; m_dir <= 1'b1; np = m_pos + W'(1);
        end else if (d == 3) begin
          m_down <= 1'b1; m_dir <= 1'b0; np = m_pos - W'(1);
        end else if (d == 2) begin
          ne = 1'b1;
        end
      end
      if (bus_if.clr) begin
        np = '0;
        ne = 1'b0;
      end
      m_pos  <= np;
      m_err  <= ne;
      m_pend <= 1'b0;
      if (hist.size() >= F + 1) begin
        v = hist[hist.size() - 2];
        same = 1'b1;
        for (int k = 2; k <= F + 1; k++)
          if (hist[hist.size() - k] != v) same = 1'b0;
        if (same && (!m_have || v != m_acc)) begin
          m_pend  <= 1'b1;
          m_first <= !m_have;
          m_old   <= m_acc;
          m_new   <= v;
          m_acc   <= v;
          m_have  <= 1'b1;
        end
      end
      hist.push_back({bus_if.a_in, bus_if.b_in});
      if (hist.size() > 16) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cyc_up",   bus_if.up,   m_up);
      check("cyc_down", bus_if.down, m_down);
      check("cyc_dir",  bus_if.dir,  m_dir);
      check("cyc_pos",  bus_if.pos,  m_pos);
      check("cyc_err",  bus_if.err,  m_err);
      check("cyc_excl", bus_if.up & bus_if.down, 1'b0);
      if (bus_if.up)   n_up++;
      if (bus_if.down) n_down++;
      $display("cyc t=%0t ab=%b%b up=%b down=%b dir=%b pos=%h err=%b", $time,
               bus_if.a_in, bus_if.b_in, bus_if.up, bus_if.down, bus_if.dir, bus_if.pos, bus_if.err);
    end
  end

  task automatic set_phase(input logic [1:0] ph, input int cyc);
    {bus_if.a_in, bus_if.b_in} = ph;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic reset_to(input logic [1:0] ph);
    {bus_if.a_in, bus_if.b_in} = ph;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    bus_if.a_in = 1'b1;
    bus_if.b_in = 1'b1;
    bus_if.clr  = 1'b0;
    #1 rst = 1'b1;
    cmp_en = 1'b1;

    // 1: prime on 11, no activity
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t1_up", bus_if.up, 1'b0);
    check("t1_down", bus_if.down, 1'b0);
    check("t1_err", bus_if.err, 1'b0);
    check("t1_pos", bus_if.pos, 16'h0000);
    check("t1_model_primed", {31'd0, m_have}, 32'd1);

    // 2: forward cycle from 00
    reset_to(2'b00);
    n_up = 0;
    {bus_if.a_in, bus_if.b_in} = 2'b01;
    repeat (4) @(negedge clk);
    check("t2_lat_early", bus_if.up, 1'b0);
    @(negedge clk);
    check("t2_lat_up", bus_if.up, 1'b1);
    repeat (3) @(negedge clk);
    set_phase(2'b11, 8);
    set_phase(2'b10, 8);
    set_phase(2'b00, 8);
    check("t2_nup", n_up, 4);
    check("t2_pos", bus_if.pos, 16'h0004);
    check("t2_dir", bus_if.dir, 1'b1);
    check("t2_model_pos", m_pos, 16'h0004);

    // 3: six reverse steps, then forward across the wrap
    n_down = 0;
    set_phase(2'b10, 8);
    set_phase(2'b11, 8);
    set_phase(2'b01, 8);
    set_phase(2'b00, 8);
    set_phase(2'b10, 8);
    set_phase(2'b11, 8);
    check("t3_ndown", n_down, 6);
    check("t3_pos", bus_if.pos, 16'hFFFE);
    check("t3_dir", bus_if.dir, 1'b0);
    set_phase(2'b10, 8);
    check("t3_pos_ffff", bus_if.pos, 16'hFFFF);
    set_phase(2'b00, 8);
    check("t3_pos_wrap", bus_if.pos, 16'h0000);
    check("t3_dir_fwd", bus_if.dir, 1'b1);

    // 4: one-cycle glitch, then an illegal jump, then clear
    n_up = 0;
    n_down = 0;
    set_phase(2'b10, 1);
    set_phase(2'b00, 8);
    check("t4_glitch_up", n_up, 0);
    check("t4_glitch_down", n_down, 0);
    check("t4_glitch_err", bus_if.err, 1'b0);
    set_phase(2'b01, 8);
    check("t4_pos1", bus_if.pos, 16'h0001);
    set_phase(2'b10, 8);
    check("t4_err", bus_if.err, 1'b1);
    check("t4_pos_hold", bus_if.pos, 16'h0001);
    bus_if.clr = 1'b1;
    @(negedge clk);
    bus_if.clr = 1'b0;
    check("t4_clr_err", bus_if.err, 1'b0);
    check("t4_clr_pos", bus_if.pos, 16'h0000);

    // 5: clr coinciding with an up pulse
    set_phase(2'b11, 8);
    check("t5_pre_pos", bus_if.pos, 16'hFFFF);
    check("t5_pre_dir", bus_if.dir, 1'b0);
    {bus_if.a_in, bus_if.b_in} = 2'b10;
    repeat (4) @(negedge clk);
    bus_if.clr = 1'b1;
    @(negedge clk);
    check("t5_up", bus_if.up, 1'b1);
    check("t5_dir", bus_if.dir, 1'b1);
    check("t5_pos", bus_if.pos, 16'h0000);
    bus_if.clr = 1'b0;
    repeat (3) @(negedge clk);

    // 6: async reset mid-stream at pos=5, then re-prime and step
    set_phase(2'b00, 8);
    set_phase(2'b01, 8);
    set_phase(2'b11, 8);
    set_phase(2'b10, 8);
    set_phase(2'b00, 8);
    check("t6_pos5", bus_if.pos, 16'h0005);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_up", bus_if.up, 1'b0);
    check("t6_rst_down", bus_if.down, 1'b0);
    check("t6_rst_dir", bus_if.dir, 1'b0);
    check("t6_rst_pos", bus_if.pos, 16'h0000);
    check("t6_rst_err", bus_if.err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    set_phase(2'b01, 8);
    check("t6_pos1", bus_if.pos, 16'h0001);
    check("t6_dir", bus_if.dir, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
